cdb_arbiter: RTL and testbench

//  Writeback / common-data-bus arbiter between the functional units (arith, lsu, mul) and the

---
 rtl/cdb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Writeback arbiter: per-unit result FIFOs feeding one registered CDB broadcast.
// Round-robin grant across ALU, LSU and MUL heads, one result per cycle.
module cdb_arbiter #(
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 5,
    parameter int DEPTH     = 2,
    parameter bit DROP_TAG0 = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              alu_valid_i,
    input  logic [TAG_W-1:0]  alu_tag_i,
    input  logic [DATA_W-1:0] alu_value_i,
    output logic              alu_ready_o,
    input  logic              lsu_valid_i,
    input  logic [TAG_W-1:0]  lsu_tag_i,
    input  logic [DATA_W-1:0] lsu_value_i,
    output logic              lsu_ready_o,
    input  logic              mul_valid_i,
    input  logic [TAG_W-1:0]  mul_tag_i,
    input  logic [DATA_W-1:0] mul_value_i,
    output logic              mul_ready_o,
    output logic              cdb_en_o,
    output logic [TAG_W-1:0]  cdb_tag_o,
    output logic [DATA_W-1:0] cdb_value_o,
    output logic [1:0]        cdb_src_o
);

    localparam int NSRC  = 3;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_W-1:0]  mem_tag   [NSRC][DEPTH];
    logic [DATA_W-1:0] mem_value [NSRC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr    [NSRC];
    logic [PTR_W-1:0]  rd_ptr    [NSRC];
    logic [CNT_W-1:0]  count     [NSRC];
    logic [1:0]        rr_ptr;

    logic [NSRC-1:0]   in_valid;
    logic [TAG_W-1:0]  in_tag   [NSRC];
    logic [DATA_W-1:0] in_value [NSRC];
    logic [NSRC-1:0]   ready;
    logic [NSRC-1:0]   nonempty;
    logic [NSRC-1:0]   push;
    logic [NSRC-1:0]   pop;
    logic              grant;
    logic [1:0]        winner;
    logic [2:0]        sel;
    logic [TAG_W-1:0]  head_tag;
    logic [DATA_W-1:0] head_value;

    assign in_valid    = {mul_valid_i, lsu_valid_i, alu_valid_i};
    assign in_tag[0]   = alu_tag_i;
    assign in_tag[1]   = lsu_tag_i;
    assign in_tag[2]   = mul_tag_i;
    assign in_value[0] = alu_value_i;
    assign in_value[1] = lsu_value_i;
    assign in_value[2] = mul_value_i;

    assign alu_ready_o = ready[0];
    assign lsu_ready_o = ready[1];
    assign mul_ready_o = ready[2];

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            ready[i] = (count[i] != CNT_W'(DEPTH));
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            nonempty[i] = (count[i] != '0);
        end
    end

    // Tag-0 results finish the handshake but never occupy a slot.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            push[i] = in_valid[i] && ready[i] && !flush_i
                      && !(DROP_TAG0 && (in_tag[i] == '0));
        end
    end

    always_comb begin
        grant  = 1'b0;
        winner = 2'd0;
        sel    = 3'd0;
        for (int k = 0; k < NSRC; k++) begin
            sel = 3'(rr_ptr) + 3'(k);
            if (sel >= 3'd3) begin
                sel = sel - 3'd3;
            end
            if (!grant && nonempty[sel[1:0]]) begin
                grant  = 1'b1;
                winner = sel[1:0];
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant) begin
            pop[winner] = 1'b1;
        end
    end

    assign head_tag   = mem_tag[winner][rd_ptr[winner]];
    assign head_value = mem_value[winner][rd_ptr[winner]];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NSRC; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem_tag[i][j]   <= '0;
                    mem_value[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (push[i]) begin
                    mem_tag[i][wr_ptr[i]]   <= in_tag[i];
                    mem_value[i][wr_ptr[i]] <= in_value[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NSRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr      <= 2'd0;
            cdb_en_o    <= 1'b0;
            cdb_tag_o   <= '0;
            cdb_value_o <= '0;
            cdb_src_o   <= 2'd0;
        end else if (flush_i) begin
            for (int i = 0; i < NSRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            cdb_en_o    <= 1'b0;
            cdb_tag_o   <= '0;
            cdb_value_o <= '0;
            cdb_src_o   <= 2'd0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            cdb_en_o <= grant;
            if (grant) begin
                rr_ptr      <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
                cdb_tag_o   <= head_tag;
                cdb_value_o <= head_value;
                cdb_src_o   <= winner;
            end else begin
                cdb_tag_o   <= '0;
                cdb_value_o <= '0;
                cdb_src_o   <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: per-source expected queues filled on
// accepted handshakes, drained and compared on every CDB broadcast.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_tag = '0;
    logic [31:0] alu_value = '0;
    logic        alu_ready;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_tag = '0;
    logic [31:0] lsu_value = '0;
    logic        lsu_ready;
    logic        mul_valid = 1'b0;
    logic [4:0]  mul_tag = '0;
    logic [31:0] mul_value = '0;
    logic        mul_ready;
    logic        cdb_en;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [1:0]  cdb_src;

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] value;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    ent_t q2[$];
    int   n_cmp = 0;
    int   n_err = 0;

    cdb_arbiter dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .flush_i    (flush),
        .alu_valid_i(alu_valid),
        .alu_tag_i  (alu_tag),
        .alu_value_i(alu_value),
        .alu_ready_o(alu_ready),
        .lsu_valid_i(lsu_valid),
        .lsu_tag_i  (lsu_tag),
        .lsu_value_i(lsu_value),
        .lsu_ready_o(lsu_ready),
        .mul_valid_i(mul_valid),
        .mul_tag_i  (mul_tag),
        .mul_value_i(mul_value),
        .mul_ready_o(mul_ready),
        .cdb_en_o   (cdb_en),
        .cdb_tag_o  (cdb_tag),
        .cdb_value_o(cdb_value),
        .cdb_src_o  (cdb_src)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so the negedge sees what the next edge takes.
    always @(negedge clk) begin : monitor
        ent_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        n_cmp++;
        if (cdb_en) begin
            if (cdb_src == 2'd0 && q0.size() > 0) begin
                e = q0.pop_front(); have = 1'b1;
            end else if (cdb_src == 2'd1 && q1.size() > 0) begin
                e = q1.pop_front(); have = 1'b1;
            end else if (cdb_src == 2'd2 && q2.size() > 0) begin
                e = q2.pop_front(); have = 1'b1;
            end
            if (!have) begin
                n_err++;
                $display("FAIL cdb_unexpected: got src=%0d tag=%0d value=%h, expected no broadcast",
                         cdb_src, cdb_tag, cdb_value);
            end else if (cdb_tag !== e.tag || cdb_value !== e.value) begin
                n_err++;
                $display("FAIL cdb_data src=%0d: got tag=%0d value=%h, expected tag=%0d value=%h",
                         cdb_src, cdb_tag, cdb_value, e.tag, e.value);
            end
        end else if ({cdb_tag, cdb_value, cdb_src} !== '0) begin
            n_err++;
            $display("FAIL cdb_idle_zero: got tag=%0d value=%h src=%0d, expected all 0",
                     cdb_tag, cdb_value, cdb_src);
        end
        if (reset || flush) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            if (alu_valid && alu_ready && alu_tag != 5'd0) q0.push_back({alu_tag, alu_value});
            if (lsu_valid && lsu_ready && lsu_tag != 5'd0) q1.push_back({lsu_tag, lsu_value});
            if (mul_valid && mul_ready && mul_tag != 5'd0) q2.push_back({mul_tag, mul_value});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_tag = '0; alu_value = '0;
        lsu_valid = 1'b0; lsu_tag = '0; lsu_value = '0;
        mul_valid = 1'b0; mul_tag = '0; mul_value = '0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while ((q0.size() + q1.size() + q2.size() > 0 || cdb_en) && c < 40) begin
            step();
            c++;
        end
        n_cmp++;
        if (c >= 40) begin
            n_err++;
            $display("FAIL %s_drain: got %0d entries pending after 40 cycles, expected 0",
                     name, q0.size() + q1.size() + q2.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({cdb_en, cdb_tag, cdb_value, cdb_src} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got en=%0b tag=%0d value=%h src=%0d, expected all 0",
                     cdb_en, cdb_tag, cdb_value, cdb_src);
        end
        n_cmp++;
        if ({alu_ready, lsu_ready, mul_ready} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_ready: got %b, expected 111", {alu_ready, lsu_ready, mul_ready});
        end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_tag = 5'd5; alu_value = 32'h1234;
        step();
        idle_inputs();
        n_cmp++;
        if (cdb_en !== 1'b0) begin
            n_err++;
            $display("FAIL single_no_bypass: got en=%0b, expected 0", cdb_en);
        end
        step();
        n_cmp++;
        if (cdb_en !== 1'b1 || cdb_tag !== 5'd5 || cdb_value !== 32'h1234 || cdb_src !== 2'd0) begin
            n_err++;
            $display("FAIL single_bcast: got en=%0b tag=%0d value=%h src=%0d, expected 1 5 00001234 0",
                     cdb_en, cdb_tag, cdb_value, cdb_src);
        end
        step();
        n_cmp++;
        if (cdb_en !== 1'b0) begin
            n_err++;
            $display("FAIL single_one_pulse: got en=%0b, expected 0", cdb_en);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] srcs[6];
        int         nout;
        int         run[3];
        int         max_run[3];
        logic [2:0] acc;
        logic [2:0] rdy;
        do_reset();
        nout = 0;
        for (int i = 0; i < 3; i++) begin
            run[i] = 0;
            max_run[i] = 0;
        end
        alu_valid = 1'b1; alu_tag = 5'd1; alu_value = 32'hA000_0000;
        lsu_valid = 1'b1; lsu_tag = 5'd2; lsu_value = 32'hB000_0000;
        mul_valid = 1'b1; mul_tag = 5'd3; mul_value = 32'hC000_0000;
        for (int c = 0; c < 14; c++) begin
            acc = {mul_ready, lsu_ready, alu_ready};
            step();
            if (acc[0]) alu_value++;
            if (acc[1]) lsu_value++;
            if (acc[2]) mul_value++;
            if (cdb_en && nout < 6) begin
                srcs[nout] = cdb_src;
                nout++;
            end
            rdy = {mul_ready, lsu_ready, alu_ready};
            for (int i = 0; i < 3; i++) begin
                run[i] = rdy[i] ? 0 : run[i] + 1;
                if (run[i] > max_run[i]) max_run[i] = run[i];
            end
        end
        idle_inputs();
        n_cmp++;
        if (nout != 6) begin
            n_err++;
            $display("FAIL rr_count: got %0d broadcasts, expected 6", nout);
        end
        for (int i = 0; i < nout; i++) begin
            n_cmp++;
            if (srcs[i] !== 2'(i % 3)) begin
                n_err++;
                $display("FAIL rr_seq[%0d]: got src=%0d, expected %0d", i, srcs[i], i % 3);
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (max_run[i] > 2) begin
                n_err++;
                $display("FAIL rr_ready_run[%0d]: got %0d cycles not ready, expected <=2",
                         i, max_run[i]);
            end
        end
        drain("rr");
    endtask

    task automatic test_mul_backpressure();
        logic [31:0] mv[3];
        int          idx;
        int          nmul;
        logic        acc;
        mv[0] = 32'h111; mv[1] = 32'h222; mv[2] = 32'h333;
        do_reset();
        idx  = 0;
        nmul = 0;
        alu_valid = 1'b1; alu_tag = 5'd4; alu_value = 32'h4444;
        lsu_valid = 1'b1; lsu_tag = 5'd6; lsu_value = 32'h6666;
        mul_valid = 1'b1; mul_tag = 5'd7; mul_value = mv[0];
        for (int c = 1; c <= 24; c++) begin
            acc = mul_valid && mul_ready;
            step();
            if (acc) begin
                idx++;
                if (idx == 3) mul_valid = 1'b0;
                else mul_value = mv[idx];
            end
            if (cdb_en && cdb_src == 2'd2) nmul++;
            if (c == 2 || c == 3) begin
                n_cmp++;
                if (mul_ready !== 1'b0 || idx != 2) begin
                    n_err++;
                    $display("FAIL mul_full@%0d: got ready=%0b accepted=%0d, expected 0 and 2",
                             c, mul_ready, idx);
                end
            end
            if (c == 8) begin
                alu_valid = 1'b0;
                lsu_valid = 1'b0;
            end
        end
        idle_inputs();
        n_cmp++;
        if (idx != 3 || nmul != 3) begin
            n_err++;
            $display("FAIL mul_total: got accepted=%0d broadcast=%0d, expected 3 and 3", idx, nmul);
        end
        drain("mul");
    endtask

    task automatic test_drop_tag0();
        int pulses;
        pulses = 0;
        alu_valid = 1'b1; alu_tag = 5'd0; alu_value = 32'hFFFF;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (alu_ready !== 1'b1) begin
                n_err++;
                $display("FAIL drop_ready[%0d]: got %0b, expected 1", c, alu_ready);
            end
            step();
            if (cdb_en) pulses++;
        end
        idle_inputs();
        for (int c = 0; c < 6; c++) begin
            step();
            if (cdb_en) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL drop_no_bcast: got %0d pulses, expected 0", pulses);
        end
    endtask

    task automatic test_flush();
        int pulses;
        pulses = 0;
        do_reset();
        alu_valid = 1'b1; alu_tag = 5'd10; alu_value = 32'hAA01;
        lsu_valid = 1'b1; lsu_tag = 5'd11; lsu_value = 32'hBB01;
        mul_valid = 1'b1; mul_tag = 5'd12; mul_value = 32'hCC01;
        step();
        alu_value = 32'hAA02;
        lsu_valid = 1'b0;
        mul_value = 32'hCC02;
        step();
        n_cmp++;
        if (lsu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_pre_ready: got lsu_ready=%0b, expected 1", lsu_ready);
        end
        alu_valid = 1'b0; mul_valid = 1'b0;
        lsu_valid = 1'b1; lsu_tag = 5'd13; lsu_value = 32'hBB02;
        flush = 1'b1;
        step();
        idle_inputs();
        n_cmp++;
        if (cdb_en !== 1'b0) begin
            n_err++;
            $display("FAIL flush_en: got %0b, expected 0", cdb_en);
        end
        n_cmp++;
        if ({alu_ready, lsu_ready, mul_ready} !== 3'b111) begin
            n_err++;
            $display("FAIL flush_ready: got %b, expected 111", {alu_ready, lsu_ready, mul_ready});
        end
        for (int c = 0; c < 8; c++) begin
            step();
            if (cdb_en) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL flush_no_bcast: got %0d pulses, expected 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_round_robin();
        test_mul_backpressure();
        test_drop_tag0();
        test_flush();
        n_cmp++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            n_err++;
            $display("FAIL final_empty: got %0d pending, expected 0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
